pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 imem_req_valid  out  1  fetch request to instruction memory.
REQ-005 imem_req_ready  in  1  memory accepts request this cycle.
REQ-006 imem_addr  out  32  fetch address; valid while imem_req_valid=1.
REQ-007 imem_rsp_valid  in  1  instruction word returned this cycle.
REQ-008 imem_rsp_data  in  32  returned instruction word.
REQ-009 instr_out  out  32  registered instruction to decode; its [15:0] feeds the sign-extend stage.
REQ-010 instr_valid  out  1  instr_out/pc_out valid for decode.
REQ-011 pc_out  out  32  address of instr_out.
REQ-012 pc_plus4_out  out  32  pc_out + 4, mod 2^32.
REQ-013 stall  in  1  decode cannot consume instr_out this cycle.
REQ-014 branch_taken  in  1  current instruction redirects to branch target.
REQ-015 branch_offset  in  32  sign-extended 16-bit immediate from the sign-extend stage.
REQ-016 jump  in  1  current instruction is J/JAL.
REQ-017 jump_index  in  26  J-type target field.
REQ-018 jr  in  1  current instruction is JR/JALR.
REQ-019 jr_target  in  32  register-sourced target.
REQ-020 fetch_fault  out  1  sticky misaligned-target flag.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, VALID, FAULT; one request outstanding at most.
REQ-022 IDLE: entered from reset; next cycle -> REQ with fetch_pc=RESET_PC.
REQ-023 REQ: imem_req_valid=1, imem_addr=fetch_pc; on imem_req_ready=1 -> WAIT, else stay (addr held stable).
REQ-024 WAIT: on imem_rsp_valid=1 capture imem_rsp_data into instr_out, pc_out=fetch_pc, -> VALID; same-cycle response with acceptance not allowed (response earliest cycle after acceptance).
REQ-025 VALID: instr_valid=1; while stall=1 hold instr_out, pc_out, pc_plus4_out, stay VALID, ignore redirect inputs.
REQ-026 VALID with stall=0: consume; compute next fetch_pc, -> REQ next cycle (minimum 3 cycles per instruction with zero-wait memory).
REQ-027 Next-PC priority: jr > jump > branch_taken > sequential.
REQ-028 jr target = jr_target; jump target = {pc_plus4_out[31:28], jump_index, 2'b00}.
REQ-029 branch target = pc_plus4_out + (branch_offset << 2), 32-bit wrap, carry discarded.
REQ-030 sequential = pc_plus4_out; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-031 Redirect inputs sampled only in VALID with stall=0; ignored in all other states.
REQ-032 Selected next PC with [1:0]!=0 -> FAULT: fetch_fault=1, no further requests, instr_valid=0, until reset.
REQ-033 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-034 instr_valid=0 in IDLE, REQ, WAIT, FAULT.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE, imem_req_valid=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, pc_out=RESET_PC, pc_plus4_out=RESET_PC+4, fetch_fault=0.
REQ-036 Reset mid-WAIT abandons the request; a late response is dropped per REQ-033.

Verification
REQ-037 Reset release, zero-wait memory returning 32'h2008_0005 -> req addr 0 at cycle 1; instr_valid at cycle 3 with instr_out=32'h2008_0005, pc_out=0.
REQ-038 imem_req_ready low 4 cycles -> imem_req_valid and imem_addr stable; stall=1 for 3 cycles in VALID -> outputs frozen, then next fetch 0x4.
REQ-039 pc_out=0x100, branch_taken=1, branch_offset=32'hFFFF_FFFE -> next fetch 0xFC; branch_taken+jump+jr all high with jr_target=0x40 -> next fetch 0x40.
REQ-040 pc_out=0x1000_0000, jump=1, jump_index=26'h000_0010 -> next fetch 0x1000_0040; pc_out=0xFFFF_FFFC sequential -> 0x0.
REQ-041 jr=1, jr_target=0x102 -> fetch_fault=1, no further imem_req_valid; rst_n pulse mid-WAIT -> outputs reset asynchronously, stale response ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Function : Instruction fetch front end. Issues one instruction-memory request
//            at a time, registers the returned word for decode, and computes
//            the next fetch address from jr / jump / branch / sequential.
//            A misaligned next address parks the unit in a sticky fault state.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        fetch_fault
);

  localparam logic [31:0] c_reset_pc_plus4 = RESET_PC + 32'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;
  logic        r_req_valid;
  logic        r_instr_valid;
  logic        r_fault;

  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;
  logic [31:0] w_next_pc;
  logic        w_misaligned;

  // Next-PC selection for the instruction currently held in VALID: jr wins over
  // jump, jump over branch, branch over fall-through. All arithmetic wraps.
  always_comb begin
    w_jump_target   = {r_pc_plus4[31:28], jump_index, 2'b00};
    w_branch_target = r_pc_plus4 + (branch_offset << 2);
    if (jr) begin
      w_next_pc = jr_target;
    end else if (jump) begin
      w_next_pc = w_jump_target;
    end else if (branch_taken) begin
      w_next_pc = w_branch_target;
    end else begin
      w_next_pc = r_pc_plus4;
    end
    w_misaligned = |w_next_pc[1:0];
  end

  // Fetch FSM with registered outputs; responses are only looked at in WAIT and
  // redirect inputs only when decode consumes the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_instr       <= 32'h0000_0000;
      r_pc          <= RESET_PC;
      r_pc_plus4    <= c_reset_pc_plus4;
      r_req_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_fetch_pc  <= RESET_PC;
          r_req_valid <= 1'b1;
          r_state     <= S_REQ;
        end
        S_REQ: begin
          // Address stays put until the memory takes it.
          if (imem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_instr       <= imem_rsp_data;
            r_pc          <= r_fetch_pc;
            r_pc_plus4    <= r_fetch_pc + 32'd4;
            r_instr_valid <= 1'b1;
            r_state       <= S_VALID;
          end
        end
        S_VALID: begin
          if (!stall) begin
            r_instr_valid <= 1'b0;
            if (w_misaligned) begin
              r_fault <= 1'b1;
              r_state <= S_FAULT;
            end else begin
              r_fetch_pc  <= w_next_pc;
              r_req_valid <= 1'b1;
              r_state     <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          // Sticky until reset: no requests, nothing presented to decode.
          r_req_valid   <= 1'b0;
          r_instr_valid <= 1'b0;
          r_fault       <= 1'b1;
        end
        default: begin
          r_req_valid   <= 1'b0;
          r_instr_valid <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_addr      = r_fetch_pc;
  assign instr_out      = r_instr;
  assign instr_valid    = r_instr_valid;
  assign pc_out         = r_pc;
  assign pc_plus4_out   = r_pc_plus4;
  assign fetch_fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Function : Self-checking bench for pc_fetch_unit. A randomized memory and
//            decode stage drive the unit; a transaction-level model predicts
//            every fetch address, instruction word and flag cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        fetch_fault;

  pc_fetch_unit #(.RESET_PC(RESET_PC_TB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .pc_out         (pc_out),
    .pc_plus4_out   (pc_plus4_out),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .jump           (jump),
    .jump_index     (jump_index),
    .jr             (jr),
    .jr_target      (jr_target),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Directed decode decisions, applied to instructions in arrival order.
  typedef struct {
    logic        jr;
    logic [31:0] jr_target;
    logic        jump;
    logic [25:0] jidx;
    logic        br;
    logic [31:0] boff;
    int          stalls;
    int          rdy_low;
    logic        chk;
    logic [31:0] exp_next;
  } dir_t;
  dir_t dir_q[$];

  function automatic dir_t mk(input logic j_r, input logic [31:0] tgt, input logic j,
                              input logic [25:0] idx, input logic b, input logic [31:0] off,
                              input int st, input int rl, input logic c, input logic [31:0] en);
    dir_t e;
    e.jr = j_r; e.jr_target = tgt; e.jump = j; e.jidx = idx; e.br = b; e.boff = off;
    e.stalls = st; e.rdy_low = rl; e.chk = c; e.exp_next = en;
    return e;
  endfunction

  // Memory contents: any address maps to a distinct word; address 0 holds 2008_0005.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h2008_0005;
  endfunction

  // Architectural next-PC rule.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic j_r,
                                           input logic [31:0] tgt, input logic j,
                                           input logic [25:0] idx, input logic b,
                                           input logic [31:0] off);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (j_r) return tgt;
    if (j)   return {p4[31:28], idx, 2'b00};
    if (b)   return p4 + off * 32'd4;
    return p4;
  endfunction

  // Transaction-level model state.
  logic        req_open, pending, have_instr, faulted, boot;
  logic [31:0] exp_fetch, pend_addr, exp_instr, exp_pc;
  int          rsp_delay, stall_left, ready_hold, n_instr, cyc, boot_cyc;
  int          ready_pct, max_delay, stray_force;
  logic        freeze_rsp, first_watch, const_armed;
  logic [31:0] const_next;

  task automatic clear_model();
    req_open = 1'b0; pending = 1'b0; have_instr = 1'b0; faulted = 1'b0;
    stall_left = 0; ready_hold = 0; const_armed = 1'b0; freeze_rsp = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_req_valid"},   32'(imem_req_valid), 32'd0);
    check({pfx, "_imem_addr"},   imem_addr, RESET_PC_TB);
    check({pfx, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({pfx, "_instr_out"},   instr_out, 32'd0);
    check({pfx, "_pc_out"},      pc_out, RESET_PC_TB);
    check({pfx, "_pc_plus4"},    pc_plus4_out, RESET_PC_TB + 32'd4);
    check({pfx, "_fault"},       32'(fetch_fault), 32'd0);
  endtask

  // One cycle: compare outputs with the model, drive the next inputs, advance the model.
  task automatic step();
    logic        consume;
    logic [31:0] nxt;
    dir_t        e;
    int          rl;
    consume = 1'b0;
    rl = 0;
    cyc++;
    check("req_valid", 32'(imem_req_valid), 32'(req_open));
    if (req_open) check("imem_addr", imem_addr, exp_fetch);
    if (const_armed && req_open) begin
      check("dir_next", imem_addr, const_next);
      const_armed = 1'b0;
    end
    check("instr_valid", 32'(instr_valid), 32'(have_instr));
    if (have_instr) begin
      check("instr_out", instr_out, exp_instr);
      check("pc_out", pc_out, exp_pc);
      check("pc_plus4", pc_plus4_out, exp_pc + 32'd4);
    end
    check("fetch_fault", 32'(fetch_fault), 32'(faulted));
    if (first_watch && have_instr) begin
      check("first_instr_cycle", 32'(cyc - boot_cyc), 32'd3);
      check("first_instr_word", instr_out, 32'h2008_0005);
      first_watch = 1'b0;
    end

    if (req_open && ready_hold > 0) begin
      imem_req_ready = 1'b0;
      ready_hold--;
    end else begin
      imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    end

    if (pending) begin
      if (freeze_rsp || rsp_delay > 0) begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (!freeze_rsp) rsp_delay--;
      end else begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
      end
    end else begin
      imem_rsp_valid = (stray_force > 0) || ($urandom_range(0, 99) < 20);
      imem_rsp_data  = $urandom;
      if (stray_force > 0) stray_force--;
    end

    jr            = ($urandom_range(0, 3) == 0);
    jr_target     = $urandom;
    jump          = ($urandom_range(0, 3) == 0);
    jump_index    = 26'($urandom);
    branch_taken  = ($urandom_range(0, 3) == 0);
    branch_offset = 32'($signed(16'($urandom)));
    stall         = ($urandom_range(0, 1) == 1);

    if (have_instr) begin
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else begin
        stall   = 1'b0;
        consume = 1'b1;
        if (dir_q.size() > 0) begin
          e = dir_q.pop_front();
          jr = e.jr; jr_target = e.jr_target; jump = e.jump; jump_index = e.jidx;
          branch_taken = e.br; branch_offset = e.boff;
          rl = e.rdy_low;
          if (e.chk) begin
            const_armed = 1'b1;
            const_next  = e.exp_next;
          end
        end else begin
          jr_target = jr_target & 32'hFFFF_FFFC;
        end
      end
    end

    if (req_open && imem_req_ready) begin
      req_open  = 1'b0;
      pending   = 1'b1;
      pend_addr = exp_fetch;
      rsp_delay = $urandom_range(0, max_delay);
    end else if (pending && imem_rsp_valid) begin
      pending    = 1'b0;
      have_instr = 1'b1;
      exp_instr  = mem_word(pend_addr);
      exp_pc     = pend_addr;
      stall_left = (dir_q.size() > 0) ? dir_q[0].stalls : $urandom_range(0, 2);
    end else if (consume) begin
      have_instr = 1'b0;
      n_instr++;
      nxt = ref_next(exp_pc, jr, jr_target, jump, jump_index, branch_taken, branch_offset);
      if (nxt[1:0] != 2'b00) begin
        faulted = 1'b1;
      end else begin
        req_open   = 1'b1;
        exp_fetch  = nxt;
        ready_hold = rl;
      end
    end
    if (boot) begin
      boot      = 1'b0;
      req_open  = 1'b1;
      exp_fetch = RESET_PC_TB;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instrs(input int n, input int max_cyc);
    int start;
    int c;
    start = n_instr;
    c = 0;
    while (n_instr < start + n && c < max_cyc) begin
      step();
      c++;
    end
    check("instr_count", 32'(n_instr), 32'(start + n));
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    clear_model();
    boot     = 1'b1;
    boot_cyc = cyc + 1;
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    stall = 1'b0; branch_taken = 1'b0; branch_offset = 32'h0; jump = 1'b0;
    jump_index = 26'h0; jr = 1'b0; jr_target = 32'h0;
    n_instr = 0; cyc = 0; boot_cyc = 0; stray_force = 0;
    exp_fetch = 32'h0; pend_addr = 32'h0; exp_instr = 32'h0; exp_pc = 32'h0;
    const_next = 32'h0; rsp_delay = 0; boot = 1'b0; first_watch = 1'b0;
    clear_model();

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");

    // Directed walk: zero-wait memory first, then stalls, held requests, redirects.
    ready_pct = 100;
    max_delay = 0;
    dir_q.push_back(mk(1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 32'h0,         3, 4, 1'b1, 32'h0000_0004));
    dir_q.push_back(mk(1'b1, 32'h0000_0100, 1'b0, 26'h0,       1'b0, 32'h0,         0, 0, 1'b1, 32'h0000_0100));
    dir_q.push_back(mk(1'b0, 32'h0,         1'b0, 26'h0,       1'b1, 32'hFFFF_FFFE, 0, 0, 1'b1, 32'h0000_00FC));
    dir_q.push_back(mk(1'b1, 32'h0000_0040, 1'b1, 26'h3FF_FFF, 1'b1, 32'h0000_0007, 1, 0, 1'b1, 32'h0000_0040));
    dir_q.push_back(mk(1'b1, 32'h1000_0000, 1'b0, 26'h0,       1'b0, 32'h0,         0, 0, 1'b1, 32'h1000_0000));
    dir_q.push_back(mk(1'b0, 32'h0,         1'b1, 26'h000_0010, 1'b0, 32'h0,        0, 0, 1'b1, 32'h1000_0040));
    dir_q.push_back(mk(1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0,       1'b0, 32'h0,         0, 0, 1'b1, 32'hFFFF_FFFC));
    dir_q.push_back(mk(1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 32'h0,         2, 0, 1'b1, 32'h0000_0000));
    release_reset();
    first_watch = 1'b1;
    run_instrs(8, 400);

    // Randomized memory latency, backpressure, stalls and redirects.
    ready_pct = 70;
    max_delay = 3;
    run_instrs(60, 3000);

    // Misaligned jr target parks the unit in FAULT for good.
    dir_q.push_back(mk(1'b1, 32'h0000_0102, 1'b0, 26'h0, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0));
    run_instrs(1, 200);
    repeat (10) step();
    check("fault_sticky", 32'(fetch_fault), 32'd1);

    // Reset asserted in the middle of WAIT, with a late response afterwards.
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst2");
    @(posedge clk);
    #1;
    release_reset();
    freeze_rsp = 1'b1;
    c = 0;
    while (!pending && c < 50) begin
      step();
      c++;
    end
    check("reach_wait", 32'(pending), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    @(posedge clk);
    #1;
    release_reset();
    stray_force = 3;
    run_instrs(6, 400);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
